// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by on-chip word memory; independent read/write engines, one burst per direction.
// Optional AXI_MEM_DECERR_EN: out-of-range beats get DECERR instead of aliasing into the memory.
module axi_mem_responder #(
    parameter int unsigned BYTES_PER_WORD = 16,
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned ID_WIDTH       = 6,
    parameter int unsigned MEM_WORDS      = 1024
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [ADDRESS_WIDTH-1:0]    S_AXI_awaddr,
    input  logic [7:0]                  S_AXI_awlen,
    input  logic [1:0]                  S_AXI_awburst,
    input  logic [ID_WIDTH-1:0]         S_AXI_awid,
    input  logic [2:0]                  S_AXI_awsize,
    input  logic [2:0]                  S_AXI_awprot,
    input  logic                        S_AXI_awlock,
    input  logic [3:0]                  S_AXI_awcache,
    input  logic [3:0]                  S_AXI_awqos,
    input  logic [3:0]                  S_AXI_awregion,
    input  logic                        S_AXI_awuser,
    input  logic                        S_AXI_awvalid,
    output logic                        S_AXI_awready,
    input  logic [BYTES_PER_WORD*8-1:0] S_AXI_wdata,
    input  logic [BYTES_PER_WORD-1:0]   S_AXI_wstrb,
    input  logic                        S_AXI_wlast,
    input  logic                        S_AXI_wvalid,
    output logic                        S_AXI_wready,
    output logic [ID_WIDTH-1:0]         S_AXI_bid,
    output logic [1:0]                  S_AXI_bresp,
    output logic                        S_AXI_buser,
    output logic                        S_AXI_bvalid,
    input  logic                        S_AXI_bready,
    input  logic [ADDRESS_WIDTH-1:0]    S_AXI_araddr,
    input  logic [7:0]                  S_AXI_arlen,
    input  logic [1:0]                  S_AXI_arburst,
    input  logic [ID_WIDTH-1:0]         S_AXI_arid,
    input  logic [2:0]                  S_AXI_arsize,
    input  logic [2:0]                  S_AXI_arprot,
    input  logic                        S_AXI_arlock,
    input  logic [3:0]                  S_AXI_arcache,
    input  logic [3:0]                  S_AXI_arqos,
    input  logic [3:0]                  S_AXI_arregion,
    input  logic                        S_AXI_aruser,
    input  logic                        S_AXI_arvalid,
    output logic                        S_AXI_arready,
    output logic [BYTES_PER_WORD*8-1:0] S_AXI_rdata,
    output logic [ID_WIDTH-1:0]         S_AXI_rid,
    output logic [1:0]                  S_AXI_rresp,
    output logic                        S_AXI_rlast,
    output logic                        S_AXI_ruser,
    output logic                        S_AXI_rvalid,
    input  logic                        S_AXI_rready
);
    localparam int unsigned DW    = BYTES_PER_WORD * 8;
    localparam int unsigned OFF_W = $clog2(BYTES_PER_WORD);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned WA_W  = ADDRESS_WIDTH - OFF_W;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    logic [DW-1:0] r_mem [MEM_WORDS];

    wstate_t             r_wstate, w_wstate_nxt;
    logic [WA_W-1:0]     r_waddr, w_waddr_nxt, w_wstep;
    logic [7:0]          r_wlen, w_wlen_nxt, r_wcnt, w_wcnt_nxt;
    logic [1:0]          r_wburst, w_wburst_nxt;
    logic [ID_WIDTH-1:0] r_awid, w_awid_nxt, r_bid, w_bid_nxt;
    logic                r_werr, w_werr_nxt, r_wdec, w_wdec_nxt;
    logic                r_awready, w_awready_nxt, r_wready, w_wready_nxt;
    logic                r_bvalid, w_bvalid_nxt;
    logic [1:0]          r_bresp, w_bresp_nxt;
    logic                w_wlast_beat, w_woor, w_mem_we;

    rstate_t             r_rstate, w_rstate_nxt;
    logic [WA_W-1:0]     r_raddr, w_raddr_nxt, w_rstep;
    logic [7:0]          r_rlen, w_rlen_nxt, r_rcnt, w_rcnt_nxt;
    logic [1:0]          r_rburst, w_rburst_nxt;
    logic [ID_WIDTH-1:0] r_arid, w_arid_nxt, r_rid, w_rid_nxt;
    logic                r_arready, w_arready_nxt, r_rvalid, w_rvalid_nxt;
    logic                r_rlast, w_rlast_nxt;
    logic [1:0]          r_rresp, w_rresp_nxt;
    logic [DW-1:0]       r_rdata, w_rdata_nxt, w_mem_rd;
    logic                w_roor;

    logic w_unused;
    assign w_unused = ^{S_AXI_awsize, S_AXI_awprot, S_AXI_awlock, S_AXI_awcache, S_AXI_awqos,
                        S_AXI_awregion, S_AXI_awuser, S_AXI_arsize, S_AXI_arprot, S_AXI_arlock,
                        S_AXI_arcache, S_AXI_arqos, S_AXI_arregion, S_AXI_aruser,
                        S_AXI_awaddr[OFF_W-1:0], S_AXI_araddr[OFF_W-1:0]};

    assign w_wstep      = (r_wburst == 2'b00) ? r_waddr : r_waddr + WA_W'(1);
    assign w_rstep      = (r_rburst == 2'b00) ? r_raddr : r_raddr + WA_W'(1);
    assign w_wlast_beat = (r_wcnt == r_wlen);
    assign w_mem_rd     = r_mem[r_raddr[IDX_W-1:0]];
`ifdef AXI_MEM_DECERR_EN
    assign w_woor = |r_waddr[WA_W-1:IDX_W];
    assign w_roor = |r_raddr[WA_W-1:IDX_W];
`else
    assign w_woor = 1'b0;
    assign w_roor = 1'b0;
`endif

    // Write engine next-state and registered-output values
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_waddr_nxt  = r_waddr;
        w_wlen_nxt   = r_wlen;
        w_wcnt_nxt   = r_wcnt;
        w_wburst_nxt = r_wburst;
        w_awid_nxt   = r_awid;
        w_werr_nxt   = r_werr;
        w_wdec_nxt   = r_wdec;
        w_bid_nxt    = r_bid;
        w_bresp_nxt  = r_bresp;
        w_bvalid_nxt = r_bvalid;
        w_mem_we     = 1'b0;
        case (r_wstate)
            W_IDLE: if (S_AXI_awvalid && r_awready) begin
                w_waddr_nxt  = S_AXI_awaddr[ADDRESS_WIDTH-1:OFF_W];
                w_wlen_nxt   = S_AXI_awlen;
                w_wburst_nxt = S_AXI_awburst;
                w_awid_nxt   = S_AXI_awid;
                w_wcnt_nxt   = 8'd0;
                w_werr_nxt   = 1'b0;
                w_wdec_nxt   = 1'b0;
                w_wstate_nxt = W_DATA;
            end
            W_DATA: if (S_AXI_wvalid && r_wready) begin
                w_mem_we    = ~w_woor;
                w_werr_nxt  = r_werr | (S_AXI_wlast != w_wlast_beat);
                w_wdec_nxt  = r_wdec | w_woor;
                w_waddr_nxt = w_wstep;
                w_wcnt_nxt  = r_wcnt + 8'd1;
                if (w_wlast_beat) begin
                    w_wstate_nxt = W_RESP;
                    w_bvalid_nxt = 1'b1;
                    w_bid_nxt    = r_awid;
                    w_bresp_nxt  = w_werr_nxt ? 2'b10 : (w_wdec_nxt ? 2'b11 : 2'b00);
                end
            end
            W_RESP: if (S_AXI_bready && r_bvalid) begin
                w_bvalid_nxt = 1'b0;
                w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
        w_awready_nxt = (w_wstate_nxt == W_IDLE);
        w_wready_nxt  = (w_wstate_nxt == W_DATA);
    end

    // Read engine; rdata is captured from the array in R_FETCH (read-first vs. same-cycle write)
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_raddr_nxt  = r_raddr;
        w_rlen_nxt   = r_rlen;
        w_rcnt_nxt   = r_rcnt;
        w_rburst_nxt = r_rburst;
        w_arid_nxt   = r_arid;
        w_rid_nxt    = r_rid;
        w_rresp_nxt  = r_rresp;
        w_rdata_nxt  = r_rdata;
        w_rlast_nxt  = r_rlast;
        w_rvalid_nxt = r_rvalid;
        case (r_rstate)
            R_IDLE: if (S_AXI_arvalid && r_arready) begin
                w_raddr_nxt  = S_AXI_araddr[ADDRESS_WIDTH-1:OFF_W];
                w_rlen_nxt   = S_AXI_arlen;
                w_rburst_nxt = S_AXI_arburst;
                w_arid_nxt   = S_AXI_arid;
                w_rcnt_nxt   = 8'd0;
                w_rstate_nxt = R_FETCH;
            end
            R_FETCH: begin
                w_rdata_nxt  = w_roor ? '0 : w_mem_rd;
                w_rresp_nxt  = w_roor ? 2'b11 : 2'b00;
                w_rid_nxt    = r_arid;
                w_rlast_nxt  = (r_rcnt == r_rlen);
                w_rvalid_nxt = 1'b1;
                w_rstate_nxt = R_DATA;
            end
            R_DATA: if (S_AXI_rready && r_rvalid) begin
                w_rvalid_nxt = 1'b0;
                w_rlast_nxt  = 1'b0;
                if (r_rlast) begin
                    w_rstate_nxt = R_IDLE;
                end else begin
                    w_raddr_nxt  = w_rstep;
                    w_rcnt_nxt   = r_rcnt + 8'd1;
                    w_rstate_nxt = R_FETCH;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
        w_arready_nxt = (w_rstate_nxt == R_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_wstate  <= W_IDLE;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_wburst  <= '0;
            r_awid    <= '0;
            r_werr    <= 1'b0;
            r_wdec    <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= '0;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_rstate  <= R_IDLE;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rburst  <= '0;
            r_arid    <= '0;
            r_rid     <= '0;
            r_rresp   <= '0;
            r_rdata   <= '0;
            r_rlast   <= 1'b0;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wlen    <= w_wlen_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_wburst  <= w_wburst_nxt;
            r_awid    <= w_awid_nxt;
            r_werr    <= w_werr_nxt;
            r_wdec    <= w_wdec_nxt;
            r_bid     <= w_bid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_rstate  <= w_rstate_nxt;
            r_raddr   <= w_raddr_nxt;
            r_rlen    <= w_rlen_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_rburst  <= w_rburst_nxt;
            r_arid    <= w_arid_nxt;
            r_rid     <= w_rid_nxt;
            r_rresp   <= w_rresp_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rlast   <= w_rlast_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_arready <= w_arready_nxt;
        end
    end

    // Memory array is never reset so contents survive RST_N
    always_ff @(posedge CLK) begin
        for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
            if (w_mem_we && S_AXI_wstrb[b]) begin
                r_mem[r_waddr[IDX_W-1:0]][b*8 +: 8] <= S_AXI_wdata[b*8 +: 8];
            end
        end
    end

    assign S_AXI_awready = r_awready;
    assign S_AXI_wready  = r_wready;
    assign S_AXI_bid     = r_bid;
    assign S_AXI_bresp   = r_bresp;
    assign S_AXI_buser   = 1'b0;
    assign S_AXI_bvalid  = r_bvalid;
    assign S_AXI_arready = r_arready;
    assign S_AXI_rdata   = r_rdata;
    assign S_AXI_rid     = r_rid;
    assign S_AXI_rresp   = r_rresp;
    assign S_AXI_rlast   = r_rlast;
    assign S_AXI_ruser   = 1'b0;
    assign S_AXI_rvalid  = r_rvalid;
endmodule
